// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - shared types and constants for the RAM BIST controller
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAT_ZERO = 2'b00,
    PAT_ONES = 2'b01,
    PAT_CHK  = 2'b10,
    PAT_ADDR = 2'b11
  } pat_e;

  localparam logic [7:0] CHK_EVEN = 8'hAA;
  localparam logic [7:0] CHK_ODD  = 8'h55;

endpackage

// File: rtl/ram_bist_if.sv
// rtl/ram_bist_if.sv - single-port RAM access bus between BIST initiator and RAM
interface ram_bist_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport master (output ram_addr, ram_data, ram_wren, input ram_q);
  modport slave  (input ram_addr, ram_data, ram_wren, output ram_q);
endinterface

// File: rtl/ram_bist_pattern.sv
// rtl/ram_bist_pattern.sv - combinational test pattern generator: (pattern, address) -> data
module ram_bist_pattern
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  pat_e              sel_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = '0;
    case (sel_i)
      PAT_ZERO: data_o = '0;
      PAT_ONES: data_o = '1;
      PAT_CHK:  data_o = addr_i[0] ? DATA_W'(CHK_ODD) : DATA_W'(CHK_EVEN);
      PAT_ADDR: data_o = DATA_W'(addr_i);
      default:  data_o = '0;
    endcase
  end

endmodule

// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - write/read-back BIST sweep over a single-port synchronous RAM
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        pattern_sel_i,
  ram_bist_if.master        ram,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [ADDR_W:0]   err_count_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e            state_q, state_d;
  pat_e              sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic [1:0]        drain_q, drain_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              pass_q, pass_d;
  logic [RD_LAT-1:0] pipe_vld_q;
  logic [ADDR_W-1:0] pipe_addr_q [RD_LAT];
  logic [DATA_W-1:0] cmp_data;

  ram_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_pat (
    .sel_i (sel_d),
    .addr_i(addr_d),
    .data_o(data_d)
  );

  ram_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp_pat (
    .sel_i (sel_q),
    .addr_i(pipe_addr_q[RD_LAT-1]),
    .data_o(cmp_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= PAT_ZERO;
      addr_q      <= '0;
      data_q      <= '0;
      wren_q      <= 1'b0;
      drain_q     <= '0;
      err_count_q <= '0;
      err_addr_q  <= '0;
      pass_q      <= 1'b0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_addr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      drain_q     <= drain_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
      pass_q      <= pass_d;
      // Tag each read address so its data is checked exactly RD_LAT cycles later.
      pipe_vld_q[0]  <= (state_q == READ);
      pipe_addr_q[0] <= addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wren_d      = 1'b0;
    drain_d     = drain_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    pass_d      = pass_q;

    if (pipe_vld_q[RD_LAT-1] && (ram.ram_q != cmp_data)) begin
      err_count_d = err_count_q + CNT_W'(1);
      if (err_count_q == '0) err_addr_d = pipe_addr_q[RD_LAT-1];
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = WRITE;
          sel_d       = pat_e'(pattern_sel_i);
          addr_d      = '0;
          wren_d      = 1'b1;
          err_count_d = '0;
          err_addr_d  = '0;
          pass_d      = 1'b0;
        end
      end
      WRITE: begin
        wren_d = 1'b1;
        if (addr_q == ADDR_MAX) begin
          state_d = READ;
          addr_d  = '0;
          wren_d  = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      READ: begin
        if (addr_q == ADDR_MAX) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == 2'(RD_LAT - 1)) begin
          state_d = DONE;
          pass_d  = (err_count_d == '0);
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram.ram_addr = addr_q;
  assign ram.ram_data = data_q;
  assign ram.ram_wren = wren_q;

  assign busy_o      = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);
  assign pass_o      = pass_q;
  assign err_addr_o  = err_addr_q;
  assign err_count_o = err_count_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb/tb_ram_bist_ctrl.sv - directed self-checking bench for ram_bist_ctrl with faulty RAM models
module tb_ram_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start3;
  logic [1:0] sel, sel3;
  logic       busy, done, pass, busy3, done3, pass3;
  logic [4:0] err_addr, err_addr3;
  logic [5:0] err_count, err_count3;

  int checks   = 0;
  int failures = 0;
  int stuck    = -1;
  int stuck3   = -1;
  bit alias_en = 1'b0;
  int edges, wrens;

  logic [7:0] mem  [32];
  logic [7:0] mem3 [32];
  logic [7:0] q1, q2, q3;

  always #5 clk = ~clk;

  ram_bist_if #(.ADDR_W(5), .DATA_W(8)) bus ();
  ram_bist_if #(.ADDR_W(5), .DATA_W(8)) bus3 ();

  ram_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start_i(start), .pattern_sel_i(sel), .ram(bus),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_addr_o(err_addr), .err_count_o(err_count)
  );

  ram_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start_i(start3), .pattern_sel_i(sel3), .ram(bus3),
    .busy_o(busy3), .done_o(done3), .pass_o(pass3), .err_addr_o(err_addr3), .err_count_o(err_count3)
  );

  // RD_LAT=1 RAM with stuck-at-0 bit0 and upper-half aliasing hooks.
  always @(posedge clk) begin
    logic [4:0] ea;
    ea = alias_en ? {1'b0, bus.ram_addr[3:0]} : bus.ram_addr;
    if (bus.ram_wren) mem[ea] <= (int'(ea) == stuck) ? (bus.ram_data & 8'hFE) : bus.ram_data;
    bus.ram_q <= mem[ea];
  end

  always @(posedge clk) begin
    if (bus3.ram_wren)
      mem3[bus3.ram_addr] <= (int'(bus3.ram_addr) == stuck3) ? (bus3.ram_data & 8'hFE) : bus3.ram_data;
    q1 <= mem3[bus3.ram_addr];
    q2 <= q1;
    q3 <= q2;
  end
  assign bus3.ram_q = q3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input bit use3, input logic [1:0] s);
    @(negedge clk);
    if (use3) begin start3 = 1'b1; sel3 = s; end
    else begin start = 1'b1; sel = s; end
    @(negedge clk);
    start  = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input bit use3, input int poke_at, output int n, output int w);
    n = 0;
    w = (use3 ? bus3.ram_wren : bus.ram_wren) ? 1 : 0;
    while (!(use3 ? done3 : done) && n < 300) begin
      start = (n == poke_at);
      @(negedge clk);
      n++;
      if (use3 ? bus3.ram_wren : bus.ram_wren) w++;
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mem[i] = 8'h00; mem3[i] = 8'h00; end
    rst = 1'b1; start = 1'b0; start3 = 1'b0; sel = 2'b00; sel3 = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_addr",  32'(bus.ram_addr), 32'd0);
    check("rst_data",  32'(bus.ram_data), 32'd0);
    check("rst_wren",  32'(bus.ram_wren), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_pass",  32'(pass), 32'd0);
    check("rst_eaddr", 32'(err_addr), 32'd0);
    check("rst_ecnt",  32'(err_count), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    rst = 1'b0;

    // Zeros, clean RAM
    pulse(1'b0, 2'b00);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_wren", 32'(bus.ram_wren), 32'd1);
    check("t1_addr", 32'(bus.ram_addr), 32'd0);
    wait_done(1'b0, -1, edges, wrens);
    check("t1_edges", 32'(edges), 32'd65);
    check("t1_wrens", 32'(wrens), 32'd32);
    check("t1_done",  32'(done), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_pass",  32'(pass), 32'd1);
    check("t1_ecnt",  32'(err_count), 32'd0);
    check("t1_eaddr", 32'(err_addr), 32'd0);

    // Checkerboard with addr 5 bit0 stuck low; sel changed after start must be ignored
    stuck = 5;
    pulse(1'b0, 2'b10);
    sel = 2'b00;
    check("t2_data0", 32'(bus.ram_data), 32'hAA);
    @(negedge clk);
    check("t2_data1", 32'(bus.ram_data), 32'h55);
    wait_done(1'b0, -1, edges, wrens);
    check("t2_done",  32'(done), 32'd1);
    check("t2_pass",  32'(pass), 32'd0);
    check("t2_ecnt",  32'(err_count), 32'd1);
    check("t2_eaddr", 32'(err_addr), 32'd5);
    stuck = -1;

    // Address-as-data with upper half aliased onto lower half
    alias_en = 1'b1;
    pulse(1'b0, 2'b11);
    wait_done(1'b0, -1, edges, wrens);
    check("t3_ecnt",  32'(err_count), 32'd16);
    check("t3_eaddr", 32'(err_addr), 32'd0);
    check("t3_pass",  32'(pass), 32'd0);
    alias_en = 1'b0;

    // Reset on the 10th write cycle
    pulse(1'b0, 2'b01);
    repeat (9) @(negedge clk);
    check("t4_addr9", 32'(bus.ram_addr), 32'd9);
    check("t4_wren9", 32'(bus.ram_wren), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t4_wren", 32'(bus.ram_wren), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_addr", 32'(bus.ram_addr), 32'd0);
    rst = 1'b0;
    pulse(1'b0, 2'b01);
    wait_done(1'b0, -1, edges, wrens);
    check("t4_edges", 32'(edges), 32'd65);
    check("t4_pass",  32'(pass), 32'd1);

    // start pulsed mid-READ is ignored
    pulse(1'b0, 2'b11);
    wait_done(1'b0, 40, edges, wrens);
    check("t5_edges", 32'(edges), 32'd65);
    check("t5_pass",  32'(pass), 32'd1);

    // start held high: restart on the cycle after DONE with counts cleared
    stuck = 5;
    @(negedge clk);
    sel = 2'b10;
    start = 1'b1;
    @(negedge clk);
    wait_done(1'b0, -2, edges, wrens);
    start = 1'b1;
    check("t5_done1", 32'(done), 32'd1);
    check("t5_ecnt1", 32'(err_count), 32'd1);
    check("t5_pass1", 32'(pass), 32'd0);
    @(negedge clk);
    start = 1'b0;
    stuck = -1;
    check("t5_rdone", 32'(done), 32'd0);
    check("t5_rbusy", 32'(busy), 32'd1);
    check("t5_recnt", 32'(err_count), 32'd0);
    check("t5_rwren", 32'(bus.ram_wren), 32'd1);
    check("t5_raddr", 32'(bus.ram_addr), 32'd0);
    wait_done(1'b0, -1, edges, wrens);
    check("t5_done2", 32'(done), 32'd1);
    check("t5_pass2", 32'(pass), 32'd1);

    // RD_LAT=3 build, ones, addr 31 faulty
    stuck3 = 31;
    pulse(1'b1, 2'b01);
    wait_done(1'b1, -1, edges, wrens);
    check("t6_edges", 32'(edges), 32'd67);
    check("t6_wrens", 32'(wrens), 32'd32);
    check("t6_eaddr", 32'(err_addr3), 32'd31);
    check("t6_ecnt",  32'(err_count3), 32'd1);
    check("t6_pass",  32'(pass3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
